sprite_fade_compositor: RTL and testbench

// Downstream of the palette-based sprite renderer. Consumes its RGB output,

---
 rtl/sprite_fade_compositor.sv | 276 +++++++++++++++++++++++++++
 tb/tb_sprite_fade_compositor.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_fade_compositor.sv
// -----------------------------------------------------------------------------
// sprite_fade_compositor
//
// Sits after the palette-based sprite renderer. It delays the background
// pixel, the sync signals and the counters so that they line up with the
// renderer's sprite output. It then alpha-blends the sprite over the
// background in two registered stages. A sprite pixel equal to KEY_COLOR is
// treated as fully transparent. A per-frame fade FSM ramps the sprite opacity
// up or down (card reveal/hide). Opacity changes only on new_frame_in.
//
// Parameters
//   SPRITE_LATENCY  cycles from hcount_in to valid sprite_*_in (>= 1)
//   FADE_STEP       alpha step per frame, 1..256
//   KEY_COLOR       sprite RGB that is rendered fully transparent
//
// Ports
//   pixel_clk_in                          pixel clock, the only clock
//   rst_in                                synchronous, active-high reset
//   hcount_in[10:0], vcount_in[9:0]       counters, aligned with bg_*_in
//   hsync_in, vsync_in, active_draw_in    video timing, aligned with hcount_in
//   new_frame_in                          one-cycle pulse at frame start
//   bg_{red,green,blue}_in[7:0]           background pixel
//   sprite_{red,green,blue}_in[7:0]       sprite pixel, SPRITE_LATENCY late
//   fade_in_trig, fade_out_trig           reveal / hide requests (levels)
//   {red,green,blue}_out[7:0]             composited pixel
//   hsync_out, vsync_out, active_draw_out timing delayed to match RGB
//   hcount_out[10:0], vcount_out[9:0]     counters delayed to match RGB
//   alpha_out[8:0]                        current opacity, 0..256
//   busy_out                              high while fading in or out
// -----------------------------------------------------------------------------
module sprite_fade_compositor #(
  parameter int          SPRITE_LATENCY = 4,
  parameter int          FADE_STEP      = 16,
  parameter logic [23:0] KEY_COLOR      = 24'h000000
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        active_draw_in,
  input  logic        new_frame_in,
  input  logic [7:0]  bg_red_in,
  input  logic [7:0]  bg_green_in,
  input  logic [7:0]  bg_blue_in,
  input  logic [7:0]  sprite_red_in,
  input  logic [7:0]  sprite_green_in,
  input  logic [7:0]  sprite_blue_in,
  input  logic        fade_in_trig,
  input  logic        fade_out_trig,
  output logic [7:0]  red_out,
  output logic [7:0]  green_out,
  output logic [7:0]  blue_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        active_draw_out,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic [8:0]  alpha_out,
  output logic        busy_out
);

  typedef enum logic [1:0] {
    HIDDEN   = 2'd0,
    FADE_IN  = 2'd1,
    SHOWN    = 2'd2,
    FADE_OUT = 2'd3
  } state_t;

  // Timing and counters travel together through every pipeline stage.
  typedef struct packed {
    logic        hsync;
    logic        vsync;
    logic        active;
    logic [10:0] hcount;
    logic [9:0]  vcount;
  } timing_t;

  localparam logic [9:0] STEP_W = 10'(FADE_STEP);

  // ---------------------------------------------------------------------------
  // Fade FSM
  // ---------------------------------------------------------------------------
  state_t     r_state;
  logic [8:0] r_alpha;
  logic       r_busy;

  state_t     w_next_state;
  logic [8:0] w_next_alpha;
  logic [9:0] w_alpha_up;
  logic       w_alpha_up_full;
  logic       w_alpha_dn_empty;
  logic [8:0] w_alpha_dn;
  logic       w_in_req;

  assign w_alpha_up       = {1'b0, r_alpha} + STEP_W;
  assign w_alpha_up_full  = (w_alpha_up >= 10'd256);
  assign w_alpha_dn_empty = ({1'b0, r_alpha} <= STEP_W);
  assign w_alpha_dn       = r_alpha - STEP_W[8:0];
  // A simultaneous hide request overrides a reveal request.
  assign w_in_req         = fade_in_trig && !fade_out_trig;

  // The alpha step uses the current state; a trigger seen in the same cycle
  // changes the state only, so the new direction applies from the next frame.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    w_next_state = r_state;
    w_next_alpha = r_alpha;
    case (r_state)
      HIDDEN: begin
        if (w_in_req) w_next_state = FADE_IN;
      end
      FADE_IN: begin
        if (new_frame_in) begin
          if (w_alpha_up_full) begin
            w_next_alpha = 9'd256;
            w_next_state = SHOWN;
          end else begin
            w_next_alpha = w_alpha_up[8:0];
          end
        end
        if (fade_out_trig) w_next_state = FADE_OUT;
      end
      SHOWN: begin
        if (fade_out_trig) w_next_state = FADE_OUT;
      end
      FADE_OUT: begin
        if (new_frame_in) begin
          if (w_alpha_dn_empty) begin
            w_next_alpha = 9'd0;
            w_next_state = HIDDEN;
          end else begin
            w_next_alpha = w_alpha_dn;
          end
        end
        if (w_in_req) w_next_state = FADE_IN;
      end
      default: begin
        w_next_state = HIDDEN;
        w_next_alpha = 9'd0;
      end
    endcase
  end

  always_ff @(posedge pixel_clk_in) begin
    // NOTE: sequential state is written with non-blocking assignments so all
    // registers update together from values sampled at the same edge.
    if (rst_in) begin
      r_state <= HIDDEN;
      r_alpha <= 9'd0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_alpha <= w_next_alpha;
      r_busy  <= (w_next_state == FADE_IN) || (w_next_state == FADE_OUT);
    end
  end

  // ---------------------------------------------------------------------------
  // Delay line: background and timing wait for the sprite renderer
  // ---------------------------------------------------------------------------
  timing_t     w_tim_in;
  logic [23:0] w_bg_in;
  timing_t     r_tim_dly [SPRITE_LATENCY];
  logic [23:0] r_bg_dly  [SPRITE_LATENCY];

  assign w_tim_in = {hsync_in, vsync_in, active_draw_in, hcount_in, vcount_in};
  assign w_bg_in  = {bg_red_in, bg_green_in, bg_blue_in};

  always_ff @(posedge pixel_clk_in) begin
    // NOTE: the delay stages are reset on purpose so that a reset flushes the
    // whole pipeline to zeros and no stale pixel reaches the output afterwards.
    if (rst_in) begin
      for (int i = 0; i < SPRITE_LATENCY; i++) begin
        r_tim_dly[i] <= '0;
        r_bg_dly[i]  <= '0;
      end
    end else begin
      r_tim_dly[0] <= w_tim_in;
      r_bg_dly[0]  <= w_bg_in;
      for (int i = 1; i < SPRITE_LATENCY; i++) begin
        r_tim_dly[i] <= r_tim_dly[i-1];
        r_bg_dly[i]  <= r_bg_dly[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Blend stage 1: per-channel weighted products
  // ---------------------------------------------------------------------------
  logic [23:0]       w_spr;
  logic [23:0]       w_bg_al;
  logic [8:0]        w_a_px;
  logic [8:0]        w_a_inv;
  logic [2:0][16:0]  w_ps;
  logic [2:0][16:0]  w_pb;

  timing_t           r_s1_tim;
  logic [2:0][16:0]  r_ps;
  logic [2:0][16:0]  r_pb;

  assign w_spr   = {sprite_red_in, sprite_green_in, sprite_blue_in};
  assign w_bg_al = r_bg_dly[SPRITE_LATENCY-1];
  // Key-coloured sprite pixels let the background through untouched.
  assign w_a_px  = (w_spr == KEY_COLOR) ? 9'd0 : r_alpha;
  assign w_a_inv = 9'd256 - w_a_px;

  // Channel 2 = red, 1 = green, 0 = blue.
  always_comb begin
    w_ps = '0;
    w_pb = '0;
    for (int ch = 0; ch < 3; ch++) begin
      w_ps[ch] = {9'd0, w_spr[ch*8 +: 8]}   * {8'd0, w_a_px};
      w_pb[ch] = {9'd0, w_bg_al[ch*8 +: 8]} * {8'd0, w_a_inv};
    end
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      r_s1_tim <= '0;
      r_ps     <= '0;
      r_pb     <= '0;
    end else begin
      r_s1_tim <= r_tim_dly[SPRITE_LATENCY-1];
      r_ps     <= w_ps;
      r_pb     <= w_pb;
    end
  end

  // ---------------------------------------------------------------------------
  // Blend stage 2: sum, scale by 1/256, blank outside the active area
  // ---------------------------------------------------------------------------
  logic [2:0][16:0] w_sum;
  logic [23:0]      w_pix;

  timing_t          r_s2_tim;
  logic [23:0]      r_rgb;

  // The sum never exceeds 255*256, so bit 16 stays clear; the clamp is purely
  // defensive.
  always_comb begin
    w_sum = '0;
    w_pix = '0;
    for (int ch = 0; ch < 3; ch++) begin
      w_sum[ch]          = r_ps[ch] + r_pb[ch];
      w_pix[ch*8 +: 8]   = w_sum[ch][16] ? 8'hFF : w_sum[ch][15:8];
    end
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      r_s2_tim <= '0;
      r_rgb    <= '0;
    end else begin
      r_s2_tim <= r_s1_tim;
      r_rgb    <= r_s1_tim.active ? w_pix : 24'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign red_out         = r_rgb[23:16];
  assign green_out       = r_rgb[15:8];
  assign blue_out        = r_rgb[7:0];
  assign hsync_out       = r_s2_tim.hsync;
  assign vsync_out       = r_s2_tim.vsync;
  assign active_draw_out = r_s2_tim.active;
  assign hcount_out      = r_s2_tim.hcount;
  assign vcount_out      = r_s2_tim.vcount;
  assign alpha_out       = r_alpha;
  assign busy_out        = r_busy;

endmodule

// File: tb/tb_sprite_fade_compositor.sv
// -----------------------------------------------------------------------------
// tb_sprite_fade_compositor
//
// Directed bench for sprite_fade_compositor. Two instances share all inputs:
// dut_a uses FADE_STEP=64 and dut_b uses FADE_STEP=100. Inputs are driven
// just after the falling edge. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_sprite_fade_compositor;

  logic        clk;
  logic        rst;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync, vsync, active;
  logic        new_frame;
  logic [23:0] bg, spr;
  logic        fin, fout;

  logic [7:0]  a_r, a_g, a_b;
  logic        a_hs, a_vs, a_act;
  logic [10:0] a_hc;
  logic [9:0]  a_vc;
  logic [8:0]  a_alpha;
  logic        a_busy;

  logic [7:0]  b_r, b_g, b_b;
  logic        b_hs, b_vs, b_act;
  logic [10:0] b_hc;
  logic [9:0]  b_vc;
  logic [8:0]  b_alpha;
  logic        b_busy;

  int errors = 0;
  int checks = 0;

  sprite_fade_compositor #(.SPRITE_LATENCY(4), .FADE_STEP(64), .KEY_COLOR(24'h000000)) dut_a (
    .pixel_clk_in(clk), .rst_in(rst),
    .hcount_in(hcount), .vcount_in(vcount),
    .hsync_in(hsync), .vsync_in(vsync), .active_draw_in(active),
    .new_frame_in(new_frame),
    .bg_red_in(bg[23:16]), .bg_green_in(bg[15:8]), .bg_blue_in(bg[7:0]),
    .sprite_red_in(spr[23:16]), .sprite_green_in(spr[15:8]), .sprite_blue_in(spr[7:0]),
    .fade_in_trig(fin), .fade_out_trig(fout),
    .red_out(a_r), .green_out(a_g), .blue_out(a_b),
    .hsync_out(a_hs), .vsync_out(a_vs), .active_draw_out(a_act),
    .hcount_out(a_hc), .vcount_out(a_vc),
    .alpha_out(a_alpha), .busy_out(a_busy)
  );

  sprite_fade_compositor #(.SPRITE_LATENCY(4), .FADE_STEP(100), .KEY_COLOR(24'h000000)) dut_b (
    .pixel_clk_in(clk), .rst_in(rst),
    .hcount_in(hcount), .vcount_in(vcount),
    .hsync_in(hsync), .vsync_in(vsync), .active_draw_in(active),
    .new_frame_in(new_frame),
    .bg_red_in(bg[23:16]), .bg_green_in(bg[15:8]), .bg_blue_in(bg[7:0]),
    .sprite_red_in(spr[23:16]), .sprite_green_in(spr[15:8]), .sprite_blue_in(spr[7:0]),
    .fade_in_trig(fin), .fade_out_trig(fout),
    .red_out(b_r), .green_out(b_g), .blue_out(b_b),
    .hsync_out(b_hs), .vsync_out(b_vs), .active_draw_out(b_act),
    .hcount_out(b_hc), .vcount_out(b_vc),
    .alpha_out(b_alpha), .busy_out(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no comparisons inside)
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame();
    new_frame = 1'b1;
    step(1);
    new_frame = 1'b0;
  endtask

  task automatic pulse_in();
    fin = 1'b1;
    step(1);
    fin = 1'b0;
  endtask

  task automatic pulse_out();
    fout = 1'b1;
    step(1);
    fout = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  // One pixel: timing/bg for one cycle, sprite four cycles later, then sample
  // dut_a at +5 (hcount only) and +6 (everything).
  task automatic run_pixel(input logic [10:0] hc, input logic [9:0] vc,
                           input logic [23:0] bgc, input logic [23:0] sc,
                           input logic act, input logic hs, input logic vs,
                           output logic [23:0] rgb, output logic [10:0] hc_o,
                           output logic [9:0] vc_o, output logic [2:0] tim_o,
                           output logic [10:0] hc_early);
    hcount = hc; vcount = vc; bg = bgc; active = act; hsync = hs; vsync = vs;
    step(1);
    hcount = '0; vcount = '0; bg = '0; active = 1'b0; hsync = 1'b0; vsync = 1'b0;
    step(3);
    spr = sc;
    step(1);
    spr = '0;
    hc_early = a_hc;
    step(1);
    rgb   = {a_r, a_g, a_b};
    hc_o  = a_hc;
    vc_o  = a_vc;
    tim_o = {a_hs, a_vs, a_act};
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    step(3);
    checks++;
    if ({a_r, a_g, a_b} !== 24'h0) begin
      errors++; $display("FAIL reset_rgb: got %06h want 000000", {a_r, a_g, a_b});
    end
    checks++;
    if ({a_hs, a_vs, a_act, a_hc, a_vc} !== 24'h0) begin
      errors++; $display("FAIL reset_timing: got %h want 0", {a_hs, a_vs, a_act, a_hc, a_vc});
    end
    checks++;
    if ({a_alpha, a_busy} !== 10'h0) begin
      errors++; $display("FAIL reset_alpha: alpha=%0d busy=%0d want 0/0", a_alpha, a_busy);
    end
    rst = 1'b0;
    step(1);
  endtask

  // FADE_STEP=64: 64,128,192,256 then SHOWN.
  task automatic test_fade_in();
    logic [8:0] exp_a [4];
    logic       exp_b [4];
    exp_a[0] = 9'd64;  exp_a[1] = 9'd128; exp_a[2] = 9'd192; exp_a[3] = 9'd256;
    exp_b[0] = 1'b1;   exp_b[1] = 1'b1;   exp_b[2] = 1'b1;   exp_b[3] = 1'b0;
    pulse_in();
    checks++;
    if ({a_alpha, a_busy} !== {9'd0, 1'b1}) begin
      errors++; $display("FAIL fade_in_start: alpha=%0d busy=%0d want 0/1", a_alpha, a_busy);
    end
    for (int i = 0; i < 4; i++) begin
      step(2);
      frame();
      checks++;
      if ({a_alpha, a_busy} !== {exp_a[i], exp_b[i]}) begin
        errors++; $display("FAIL fade_in_frame%0d: alpha=%0d busy=%0d want %0d/%0d",
                           i, a_alpha, a_busy, exp_a[i], exp_b[i]);
      end
      if (i == 0) begin
        // Alpha must hold between frame pulses.
        step(5);
        checks++;
        if (a_alpha !== 9'd64) begin
          errors++; $display("FAIL alpha_hold_midframe: alpha=%0d want 64", a_alpha);
        end
      end
    end
    // Reveal request while already SHOWN is ignored.
    pulse_in();
    frame();
    checks++;
    if ({a_alpha, a_busy} !== {9'd256, 1'b0}) begin
      errors++; $display("FAIL shown_ignores_fade_in: alpha=%0d busy=%0d want 256/0", a_alpha, a_busy);
    end
  endtask

  task automatic test_opaque();
    logic [23:0] rgb; logic [10:0] hc_o, hc_e; logic [9:0] vc_o; logic [2:0] tim;
    run_pixel(11'd1234, 10'd500, 24'h000000, 24'h112233, 1'b1, 1'b1, 1'b0,
              rgb, hc_o, vc_o, tim, hc_e);
    checks++;
    if (rgb !== 24'h112233) begin
      errors++; $display("FAIL opaque_rgb: got %06h want 112233", rgb);
    end
    checks++;
    if ({hc_o, vc_o, tim} !== {11'd1234, 10'd500, 3'b101}) begin
      errors++; $display("FAIL opaque_timing: hc=%0d vc=%0d hs/vs/act=%b want 1234/500/101",
                         hc_o, vc_o, tim);
    end
    checks++;
    if (hc_e !== 11'd0) begin
      errors++; $display("FAIL latency_early: hcount_out at +5 = %0d want 0", hc_e);
    end
  endtask

  task automatic test_key();
    logic [23:0] rgb; logic [10:0] hc_o, hc_e; logic [9:0] vc_o; logic [2:0] tim;
    run_pixel(11'd17, 10'd3, 24'hFF8000, 24'h000000, 1'b1, 1'b0, 1'b1,
              rgb, hc_o, vc_o, tim, hc_e);
    checks++;
    if (rgb !== 24'hFF8000) begin
      errors++; $display("FAIL key_transparent: got %06h want ff8000", rgb);
    end
    checks++;
    if ({hc_o, vc_o, tim} !== {11'd17, 10'd3, 3'b011}) begin
      errors++; $display("FAIL key_timing: hc=%0d vc=%0d hs/vs/act=%b want 17/3/011",
                         hc_o, vc_o, tim);
    end
  endtask

  task automatic test_blank();
    logic [23:0] rgb; logic [10:0] hc_o, hc_e; logic [9:0] vc_o; logic [2:0] tim;
    run_pixel(11'd900, 10'd700, 24'h123456, 24'hABCDEF, 1'b0, 1'b0, 1'b0,
              rgb, hc_o, vc_o, tim, hc_e);
    checks++;
    if ({rgb, hc_o} !== {24'h000000, 11'd900}) begin
      errors++; $display("FAIL blank_outside_active: rgb=%06h hc=%0d want 000000/900", rgb, hc_o);
    end
  endtask

  // alpha 128: (255*128)>>8 = 127 per active channel.
  task automatic test_half();
    logic [23:0] rgb; logic [10:0] hc_o, hc_e; logic [9:0] vc_o; logic [2:0] tim;
    do_reset();
    pulse_in();
    frame();
    frame();
    checks++;
    if ({a_alpha, a_busy} !== {9'd128, 1'b1}) begin
      errors++; $display("FAIL half_alpha: alpha=%0d busy=%0d want 128/1", a_alpha, a_busy);
    end
    run_pixel(11'd5, 10'd6, 24'h0000FF, 24'hFF0000, 1'b1, 1'b0, 1'b0,
              rgb, hc_o, vc_o, tim, hc_e);
    checks++;
    if (rgb !== 24'h7F007F) begin
      errors++; $display("FAIL half_blend_a: got %06h want 7f007f", rgb);
    end
    // R:(128*128+32*128)>>8=80 G:(64*128+64*128)>>8=64 B:(32*128+128*128)>>8=80
    run_pixel(11'd6, 10'd6, 24'h204080, 24'h804020, 1'b1, 1'b0, 1'b0,
              rgb, hc_o, vc_o, tim, hc_e);
    checks++;
    if (rgb !== 24'h504050) begin
      errors++; $display("FAIL half_blend_b: got %06h want 504050", rgb);
    end
  endtask

  // Still FADE_IN at alpha 128 from test_half.
  task automatic test_reset_mid_fade();
    hcount = 11'd77; vcount = 10'd9; bg = 24'hFFFFFF; spr = 24'hFFFFFF;
    active = 1'b1; hsync = 1'b1; vsync = 1'b1;
    step(7);
    checks++;
    if ({a_r, a_g, a_b, a_hc} !== {24'hFFFFFF, 11'd77}) begin
      errors++; $display("FAIL prefill: rgb=%06h hc=%0d want ffffff/77", {a_r, a_g, a_b}, a_hc);
    end
    rst = 1'b1;
    step(1);
    checks++;
    if ({a_alpha, a_busy} !== {9'd0, 1'b0}) begin
      errors++; $display("FAIL rst_mid_alpha: alpha=%0d busy=%0d want 0/0", a_alpha, a_busy);
    end
    checks++;
    if ({a_r, a_g, a_b, a_hs, a_vs, a_act, a_hc, a_vc} !== 48'h0) begin
      errors++; $display("FAIL rst_mid_outputs: rgb=%06h hs/vs/act=%b%b%b hc=%0d vc=%0d want all 0",
                         {a_r, a_g, a_b}, a_hs, a_vs, a_act, a_hc, a_vc);
    end
    hcount = '0; vcount = '0; bg = '0; spr = '0; active = 1'b0; hsync = 1'b0; vsync = 1'b0;
    rst = 1'b0;
    step(3);
    checks++;
    if ({a_r, a_g, a_b, a_hs, a_act, a_hc} !== 37'h0) begin
      errors++; $display("FAIL pipeline_flushed: rgb=%06h hc=%0d want 0", {a_r, a_g, a_b}, a_hc);
    end
    frame();
    checks++;
    if ({a_alpha, a_busy} !== {9'd0, 1'b0}) begin
      errors++; $display("FAIL hidden_after_rst: alpha=%0d busy=%0d want 0/0", a_alpha, a_busy);
    end
  endtask

  // Reverse direction mid-fade; trigger with a frame pulse in the same cycle
  // steps alpha with the old direction.
  task automatic test_reverse();
    do_reset();
    pulse_in();
    frame();
    frame();
    fout = 1'b1; new_frame = 1'b1;
    step(1);
    fout = 1'b0; new_frame = 1'b0;
    checks++;
    if ({a_alpha, a_busy} !== {9'd192, 1'b1}) begin
      errors++; $display("FAIL trig_with_frame: alpha=%0d busy=%0d want 192/1", a_alpha, a_busy);
    end
    frame();
    checks++;
    if (a_alpha !== 9'd128) begin
      errors++; $display("FAIL reverse_down: alpha=%0d want 128", a_alpha);
    end
    pulse_in();
    frame();
    checks++;
    if ({a_alpha, a_busy} !== {9'd192, 1'b1}) begin
      errors++; $display("FAIL reverse_up: alpha=%0d busy=%0d want 192/1", a_alpha, a_busy);
    end
  endtask

  // dut_b (step 100): 100,200,256 SHOWN; both triggers -> FADE_OUT 156,56,0.
  // dut_a (step 64) follows along: 64,128,192 then 128,64,0.
  task automatic test_both_triggers();
    logic [8:0] exp_b [3];
    logic [8:0] exp_a [3];
    exp_b[0] = 9'd156; exp_b[1] = 9'd56;  exp_b[2] = 9'd0;
    exp_a[0] = 9'd128; exp_a[1] = 9'd64;  exp_a[2] = 9'd0;
    do_reset();
    pulse_in();
    frame();
    frame();
    frame();
    checks++;
    if ({b_alpha, b_busy} !== {9'd256, 1'b0}) begin
      errors++; $display("FAIL b_shown: alpha=%0d busy=%0d want 256/0", b_alpha, b_busy);
    end
    fin = 1'b1; fout = 1'b1;
    step(1);
    fin = 1'b0; fout = 1'b0;
    checks++;
    if ({b_alpha, b_busy, a_alpha, a_busy} !== {9'd256, 1'b1, 9'd192, 1'b1}) begin
      errors++; $display("FAIL both_trig: b=%0d/%0d a=%0d/%0d want 256/1 192/1",
                         b_alpha, b_busy, a_alpha, a_busy);
    end
    for (int i = 0; i < 3; i++) begin
      frame();
      checks++;
      if ({b_alpha, b_busy, a_alpha, a_busy} !==
          {exp_b[i], (i != 2), exp_a[i], (i != 2)}) begin
        errors++; $display("FAIL fade_out_frame%0d: b=%0d/%0d a=%0d/%0d want %0d/%0d %0d/%0d",
                           i, b_alpha, b_busy, a_alpha, a_busy,
                           exp_b[i], (i != 2), exp_a[i], (i != 2));
      end
    end
    // Hide request while HIDDEN is ignored.
    pulse_out();
    frame();
    checks++;
    if ({b_alpha, b_busy} !== {9'd0, 1'b0}) begin
      errors++; $display("FAIL hidden_ignores_fade_out: alpha=%0d busy=%0d want 0/0", b_alpha, b_busy);
    end
  endtask

  initial begin
    rst = 1'b1; hcount = '0; vcount = '0; hsync = 1'b0; vsync = 1'b0; active = 1'b0;
    new_frame = 1'b0; bg = '0; spr = '0; fin = 1'b0; fout = 1'b0;
    step(1);
    test_reset();
    test_fade_in();
    test_opaque();
    test_key();
    test_blank();
    test_half();
    test_reset_mid_fade();
    test_reverse();
    test_both_triggers();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
